// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch / next-PC stage of the unpipelined MIPS core.
// Holds the PC, fetches one word per instruction over a req/ack handshake,
// presents it to the decoder until retire, then steps the PC using the
// decoder's branch/bne/jump flags and the ALU zero flag.
//
// Ports:
//   clk, rst_n         clock (rising edge), synchronous active-low reset
//   imem_addr/req      fetch address (always pc) and request
//   imem_rdata/ack     returned instruction word and its valid strobe
//   instr/opcode       captured instruction and its [31:26] field
//   instr_valid        instruction held, awaiting retire
//   retire             datapath finished the current instruction
//   branch/not_branch/jump/zero/imm_ext  next-PC controls, sampled on retire
//   pc/pc_plus4        current PC and PC+4
//   fetch_err          sticky fetch timeout
//   retire_cnt         retired instruction count
module fetch_unit #(
   parameter logic [31:0] PC_RESET = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic        instr_valid,
   input  logic        retire,
   input  logic        branch,
   input  logic        not_branch,
   input  logic        jump,
   input  logic        zero,
   input  logic [31:0] imm_ext,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_err,
   output logic [31:0] retire_cnt
);

   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_ISSUE, S_HALT} state_t;

   state_t          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [31:0]     instr_q, instr_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;
   logic [31:0]     rcnt_q, rcnt_d;
   logic [CW-1:0]   tcnt_q, tcnt_d;
   logic [31:0]     next_pc;
   logic            br_taken;
   logic            unused_imm_hi;

   // Branch offset is a word offset, so the top two imm bits shift out.
   assign unused_imm_hi = ^imm_ext[31:30];

   assign pc_plus4    = pc_q + 32'd4;
   assign pc          = pc_q;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign opcode      = instr_q[31:26];
   assign instr_valid = valid_q;
   assign fetch_err   = err_q;
   assign retire_cnt  = rcnt_q;

   // With both beq and bne set, either condition takes the branch.
   assign br_taken = (branch & zero) | (not_branch & ~zero);

   always_comb begin
      next_pc = pc_plus4;
      if (jump)
         next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      else if (br_taken)
         next_pc = pc_plus4 + {imm_ext[29:0], 2'b00};
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      valid_d  = valid_q;
      err_d    = err_q;
      rcnt_d   = rcnt_q;
      tcnt_d   = tcnt_q;
      imem_req = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               instr_d = imem_rdata;
               valid_d = 1'b1;
               tcnt_d  = '0;
               state_d = S_ISSUE;
            end else if (tcnt_q == CW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               tcnt_d  = '0;
               state_d = S_HALT;
            end else begin
               tcnt_d  = tcnt_q + CW'(1);
            end
         end
         S_ISSUE: begin
            if (retire) begin
               pc_d    = next_pc;
               rcnt_d  = rcnt_q + 32'd1;
               valid_d = 1'b0;
               state_d = S_REQ;
            end
         end
         S_HALT:  valid_d = 1'b0;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= PC_RESET;
         instr_q <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         rcnt_q  <= '0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         rcnt_q  <= rcnt_d;
         tcnt_q  <= tcnt_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed vector table, randomized instruction
// stream against a behavioural next-PC model, and timeout/reset sequences.
module tb_fetch_unit;

   logic        clk, rst_n;
   logic [31:0] imem_rdata, imm_ext;
   logic        imem_ack, retire, branch, not_branch, jump, zero;

   logic [31:0] imem_addr, instr, pc, pc_plus4, retire_cnt;
   logic        imem_req, instr_valid, fetch_err;
   logic [5:0]  opcode;

   logic [31:0] w_imem_addr, w_instr, w_pc, w_pc_plus4, w_retire_cnt;
   logic        w_imem_req, w_instr_valid, w_fetch_err;
   logic [5:0]  w_opcode;

   fetch_unit u_dut (
      .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_req(imem_req),
      .imem_rdata(imem_rdata), .imem_ack(imem_ack), .instr(instr), .opcode(opcode),
      .instr_valid(instr_valid), .retire(retire), .branch(branch),
      .not_branch(not_branch), .jump(jump), .zero(zero), .imm_ext(imm_ext),
      .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err), .retire_cnt(retire_cnt)
   );

   // Second instance exercises the PC wrap at the top of the address space.
   fetch_unit #(.PC_RESET(32'hFFFF_FFFC)) u_wrap (
      .clk(clk), .rst_n(rst_n), .imem_addr(w_imem_addr), .imem_req(w_imem_req),
      .imem_rdata(imem_rdata), .imem_ack(imem_ack), .instr(w_instr), .opcode(w_opcode),
      .instr_valid(w_instr_valid), .retire(retire), .branch(branch),
      .not_branch(not_branch), .jump(jump), .zero(zero), .imm_ext(imm_ext),
      .pc(w_pc), .pc_plus4(w_pc_plus4), .fetch_err(w_fetch_err), .retire_cnt(w_retire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] m_pc;
   logic [31:0] m_rcnt;

   typedef struct {
      logic [31:0] rdata;
      int          dly;
      logic        b, nb, j, z;
      logic [31:0] imm;
      logic [31:0] exp_pc;
   } vec_t;
   vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Next PC from the ISA rules, written with plain arithmetic.
   function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ins,
                                            input logic b, input logic nb, input logic j,
                                            input logic z, input logic [31:0] imm);
      logic [31:0] seq;
      seq = cur + 32'd4;
      if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
      if ((b && z) || (nb && !z)) return seq + imm * 4;
      return seq;
   endfunction

   // One full instruction starting in REQ: dly wait states, ack, one idle
   // ISSUE cycle with junk flags, then retire with the real flags.
   task automatic run_instr(input logic [31:0] rd, input int dly, input logic b, input logic nb,
                            input logic j, input logic z, input logic [31:0] imm,
                            input logic [31:0] exp_pc);
      logic [31:0] op;
      for (int d = 0; d <= dly; d++) begin
         chk("req_hold", {31'd0, imem_req}, 32'd1);
         chk("imem_addr", imem_addr, m_pc);
         chk("valid_in_req", {31'd0, instr_valid}, 32'd0);
         imem_ack   = (d == dly);
         imem_rdata = (d == dly) ? rd : $urandom;
         retire     = 1'($urandom_range(0, 1));
         step();
      end
      imem_ack = 1'b0; retire = 1'b0; imem_rdata = $urandom;
      op = rd >> 26;
      chk("issue_valid", {31'd0, instr_valid}, 32'd1);
      chk("instr", instr, rd);
      chk("opcode", {26'd0, opcode}, op);
      chk("req_in_issue", {31'd0, imem_req}, 32'd0);
      branch = 1'($urandom_range(0, 1)); not_branch = 1'($urandom_range(0, 1));
      jump = 1'($urandom_range(0, 1)); zero = 1'($urandom_range(0, 1));
      imm_ext = $urandom; imem_ack = 1'b1;
      step();
      chk("instr_hold", instr, rd);
      chk("pc_before_retire", pc, m_pc);
      imem_ack = 1'b0;
      branch = b; not_branch = nb; jump = j; zero = z; imm_ext = imm; retire = 1'b1;
      step();
      retire = 1'b0;
      m_pc = exp_pc;
      m_rcnt = m_rcnt + 1;
      chk("next_pc", pc, exp_pc);
      chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
      chk("retire_cnt", retire_cnt, m_rcnt);
      chk("valid_clear", {31'd0, instr_valid}, 32'd0);
      chk("req_again", {31'd0, imem_req}, 32'd1);
   endtask

   initial begin
      tbl[0] = '{32'h2008_0005, 0, 0, 0, 0, 0, 32'h0,         32'h0000_0004};
      tbl[1] = '{32'h0800_0004, 5, 0, 0, 1, 0, 32'h0,         32'h0000_0010};
      tbl[2] = '{32'h1000_FFFF, 1, 1, 0, 0, 1, 32'hFFFF_FFFC, 32'h0000_0004};
      tbl[3] = '{32'h0800_0004, 0, 0, 0, 1, 0, 32'h0,         32'h0000_0010};
      tbl[4] = '{32'h1000_FFFF, 2, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0000_0014};
      tbl[5] = '{32'h0800_0008, 0, 0, 0, 1, 0, 32'h0,         32'h0000_0020};
      tbl[6] = '{32'h1400_0003, 3, 0, 1, 0, 0, 32'h0000_0003, 32'h0000_0030};
      tbl[7] = '{32'h0800_0040, 0, 1, 1, 1, 1, 32'h0000_0055, 32'h0000_0100};
      tbl[8] = '{32'h1000_0002, 0, 1, 1, 0, 1, 32'h0000_0002, 32'h0000_010C};
      tbl[9] = '{32'h1400_0001, 1, 1, 1, 0, 0, 32'h0000_0001, 32'h0000_0114};

      rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; retire = 1'b1;
      branch = 1'b0; not_branch = 1'b0; jump = 1'b0; zero = 1'b0; imm_ext = '0;
      step(); step();
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_err", {31'd0, fetch_err}, 32'd0);
      chk("rst_rcnt", retire_cnt, 32'd0);
      chk("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
      chk("wrap_rst_pc4", w_pc_plus4, 32'h0);

      // Release; ack/retire during the IDLE cycle must be ignored.
      rst_n = 1'b1;
      step();
      imem_ack = 1'b0; retire = 1'b0;
      chk("idle_ack_ignored", instr, 32'h0);
      chk("req_after_release", {31'd0, imem_req}, 32'd1);
      m_pc = 32'h0; m_rcnt = 32'h0;

      for (int i = 0; i < 10; i++) begin
         run_instr(tbl[i].rdata, tbl[i].dly, tbl[i].b, tbl[i].nb, tbl[i].j,
                   tbl[i].z, tbl[i].imm, tbl[i].exp_pc);
         if (i == 0) begin
            chk("wrap_pc", w_pc, 32'h0);
            chk("wrap_pc4", w_pc_plus4, 32'h4);
         end
      end

      for (int i = 0; i < 40; i++) begin
         logic [31:0] rd, imm, nxt;
         logic b, nb, j, z;
         rd = $urandom; imm = $urandom;
         b = 1'($urandom_range(0, 1)); nb = 1'($urandom_range(0, 1));
         j = ($urandom_range(0, 3) == 0); z = 1'($urandom_range(0, 1));
         nxt = ref_next(m_pc, rd, b, nb, j, z, imm);
         run_instr(rd, $urandom_range(0, 6), b, nb, j, z, imm, nxt);
      end

      // Reset in REQ with an ack in the same cycle: the ack is discarded.
      rst_n = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
      step();
      imem_ack = 1'b0;
      chk("midrst_instr", instr, 32'h0);
      chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
      chk("midrst_pc", pc, 32'h0);
      chk("midrst_rcnt", retire_cnt, 32'h0);
      chk("midrst_req", {31'd0, imem_req}, 32'd0);
      rst_n = 1'b1;
      step();

      // No ack: 16 REQ cycles, then HALT with fetch_err.
      for (int i = 0; i < 16; i++) begin
         chk("to_req", {31'd0, imem_req}, 32'd1);
         chk("to_err_lo", {31'd0, fetch_err}, 32'd0);
         step();
      end
      chk("to_err", {31'd0, fetch_err}, 32'd1);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);

      // Spurious traffic in HALT changes nothing.
      for (int i = 0; i < 5; i++) begin
         imem_ack = 1'b1; retire = 1'b1; jump = 1'b1; imem_rdata = $urandom;
         step();
         chk("halt_pc", pc, 32'h0);
         chk("halt_instr", instr, 32'h0);
         chk("halt_rcnt", retire_cnt, 32'h0);
         chk("halt_req_lo", {31'd0, imem_req}, 32'd0);
         chk("halt_err_sticky", {31'd0, fetch_err}, 32'd1);
      end
      imem_ack = 1'b0; retire = 1'b0; jump = 1'b0;

      rst_n = 1'b0;
      step();
      chk("rst_clears_err", {31'd0, fetch_err}, 32'd0);
      rst_n = 1'b1;
      step();
      chk("restart_req", {31'd0, imem_req}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
